// File: rtl/pcie_dma_wr_arbiter.sv
// Round-robin write arbiter: picks one DMA queue at a time and streams its
// burst onto an Avalon write master, optionally followed by a tail-pointer
// write. Bad-length headers are accepted and silently dropped.
module pcie_dma_wr_arbiter #(
    parameter int NB_REQ    = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NB_REQ-1:0]     req_valid,
    input  logic [NB_REQ*64-1:0]  req_addr,
    input  logic [NB_REQ*4-1:0]   req_len,
    input  logic [NB_REQ*512-1:0] req_data,
    input  logic [NB_REQ*64-1:0]  req_ptr_addr,
    input  logic [NB_REQ*32-1:0]  req_ptr_val,
    input  logic                  write_pointer,
    output logic [NB_REQ-1:0]     req_grant,
    output logic [NB_REQ-1:0]     req_pop,
    input  logic                  pcie_bas_waitrequest,
    output logic [63:0]           pcie_bas_address,
    output logic [63:0]           pcie_bas_byteenable,
    output logic                  pcie_bas_write,
    output logic [511:0]          pcie_bas_writedata,
    output logic [3:0]            pcie_bas_burstcount,
    output logic                  busy,
    output logic [31:0]           burst_cnt,
    output logic [31:0]           bad_len_cnt
);
    localparam int LG_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PTR} state_t;

    state_t            state_q, state_d;
    logic [LG_W-1:0]   last_grant_q, last_grant_d;
    logic [LG_W-1:0]   sel_q, sel_d;
    logic [3:0]        beat_q, beat_d;
    logic [31:0]       burst_cnt_q, burst_cnt_d;
    logic [31:0]       bad_len_cnt_q, bad_len_cnt_d;
    logic [3:0]        len_q, len_d;
    logic [63:0]       addr_q, addr_d;
    logic [63:0]       ptr_addr_q, ptr_addr_d;
    logic [31:0]       ptr_val_q, ptr_val_d;

    logic [63:0]       addr_a     [NB_REQ];
    logic [3:0]        len_a      [NB_REQ];
    logic [511:0]      data_a     [NB_REQ];
    logic [63:0]       ptr_addr_a [NB_REQ];
    logic [31:0]       ptr_val_a  [NB_REQ];

    logic              gnt_found;
    logic [LG_W-1:0]   gnt_idx;
    logic [LG_W-1:0]   cand;
    logic              len_bad;

    for (genvar g = 0; g < NB_REQ; g++) begin : g_unpack
        assign addr_a[g]     = req_addr[g*64 +: 64];
        assign len_a[g]      = req_len[g*4 +: 4];
        assign data_a[g]     = req_data[g*512 +: 512];
        assign ptr_addr_a[g] = req_ptr_addr[g*64 +: 64];
        assign ptr_val_a[g]  = req_ptr_val[g*32 +: 32];
    end

    // Round-robin search: first valid requester after the last one granted
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = last_grant_q;
        for (int i = 0; i < NB_REQ; i++) begin
            cand = (cand == LG_W'(NB_REQ - 1)) ? '0 : cand + LG_W'(1);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign len_bad = (len_a[gnt_idx] == 4'd0) || (int'(len_a[gnt_idx]) > MAX_BURST);

    // Next-state, header capture and Avalon drive; bus is quiet outside DATA/PTR
    always_comb begin
        state_d             = state_q;
        last_grant_d        = last_grant_q;
        sel_d               = sel_q;
        beat_d              = beat_q;
        burst_cnt_d         = burst_cnt_q;
        bad_len_cnt_d       = bad_len_cnt_q;
        len_d               = len_q;
        addr_d              = addr_q;
        ptr_addr_d          = ptr_addr_q;
        ptr_val_d           = ptr_val_q;
        req_grant           = '0;
        req_pop             = '0;
        pcie_bas_write      = 1'b0;
        pcie_bas_address    = '0;
        pcie_bas_byteenable = '0;
        pcie_bas_writedata  = '0;
        pcie_bas_burstcount = '0;
        case (state_q)
            IDLE: begin
                // Grant is combinational, so it is masked while reset is held
                if (gnt_found && !rst) begin
                    req_grant[gnt_idx] = 1'b1;
                    last_grant_d       = gnt_idx;
                    if (len_bad) begin
                        bad_len_cnt_d = bad_len_cnt_q + 32'd1;
                    end else begin
                        sel_d      = gnt_idx;
                        len_d      = len_a[gnt_idx];
                        addr_d     = addr_a[gnt_idx];
                        ptr_addr_d = ptr_addr_a[gnt_idx];
                        ptr_val_d  = ptr_val_a[gnt_idx];
                        beat_d     = 4'd0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                pcie_bas_write      = 1'b1;
                pcie_bas_address    = addr_q;
                pcie_bas_burstcount = len_q;
                pcie_bas_byteenable = '1;
                pcie_bas_writedata  = data_a[sel_q];
                if (!pcie_bas_waitrequest) begin
                    req_pop[sel_q] = 1'b1;
                    beat_d         = beat_q + 4'd1;
                    if (beat_q == len_q - 4'd1) begin
                        burst_cnt_d = burst_cnt_q + 32'd1;
                        state_d     = write_pointer ? PTR : IDLE;
                    end
                end
            end
            PTR: begin
                pcie_bas_write      = 1'b1;
                pcie_bas_address    = ptr_addr_q;
                pcie_bas_burstcount = 4'd1;
                pcie_bas_byteenable = 64'hF;
                pcie_bas_writedata  = {480'd0, ptr_val_q};
                if (!pcie_bas_waitrequest) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= LG_W'(NB_REQ - 1);
            sel_q         <= '0;
            beat_q        <= '0;
            burst_cnt_q   <= '0;
            bad_len_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            sel_q         <= sel_d;
            beat_q        <= beat_d;
            burst_cnt_q   <= burst_cnt_d;
            bad_len_cnt_q <= bad_len_cnt_d;
        end
    end

    // Latched header fields; only observed while the FSM is in DATA/PTR
    always_ff @(posedge clk) begin
        len_q      <= len_d;
        addr_q     <= addr_d;
        ptr_addr_q <= ptr_addr_d;
        ptr_val_q  <= ptr_val_d;
    end

    assign busy        = (state_q != IDLE);
    assign burst_cnt   = burst_cnt_q;
    assign bad_len_cnt = bad_len_cnt_q;

endmodule

// File: tb/tb_pcie_dma_wr_arbiter.sv
// Bench for pcie_dma_wr_arbiter: requesters are emulated as header queues with
// a flit stream each; a transaction-level model predicts grants and bus writes.
module tb_pcie_dma_wr_arbiter;
    localparam int NB = 4;
    localparam int MB = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NB-1:0]      req_valid;
    logic [NB*64-1:0]   req_addr;
    logic [NB*4-1:0]    req_len;
    logic [NB*512-1:0]  req_data;
    logic [NB*64-1:0]   req_ptr_addr;
    logic [NB*32-1:0]   req_ptr_val;
    logic               write_pointer;
    logic [NB-1:0]      req_grant;
    logic [NB-1:0]      req_pop;
    logic               pcie_bas_waitrequest;
    logic [63:0]        pcie_bas_address;
    logic [63:0]        pcie_bas_byteenable;
    logic               pcie_bas_write;
    logic [511:0]       pcie_bas_writedata;
    logic [3:0]         pcie_bas_burstcount;
    logic               busy;
    logic [31:0]        burst_cnt;
    logic [31:0]        bad_len_cnt;

    pcie_dma_wr_arbiter #(.NB_REQ(NB), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_data(req_data), .req_ptr_addr(req_ptr_addr), .req_ptr_val(req_ptr_val),
        .write_pointer(write_pointer), .req_grant(req_grant), .req_pop(req_pop),
        .pcie_bas_waitrequest(pcie_bas_waitrequest), .pcie_bas_address(pcie_bas_address),
        .pcie_bas_byteenable(pcie_bas_byteenable), .pcie_bas_write(pcie_bas_write),
        .pcie_bas_writedata(pcie_bas_writedata), .pcie_bas_burstcount(pcie_bas_burstcount),
        .busy(busy), .burst_cnt(burst_cnt), .bad_len_cnt(bad_len_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  len;
        logic [63:0] paddr;
        logic [31:0] pval;
    } hdr_t;

    typedef struct {
        logic [63:0]  addr;
        logic [3:0]   bc;
        logic [63:0]  be;
        logic [511:0] data;
        int           req;
        bit           is_data;
        bit           last;
        logic [63:0]  paddr;
        logic [31:0]  pval;
    } beat_t;

    hdr_t   hq [NB][$];
    beat_t  expq[$];
    int     popped [NB];
    int     glog[$];
    bit     plan[$];
    int     last_g;
    int     m_burst, m_bad;
    int     n_grant, n_wr, n_pop, n_beats;
    int     ev_grant, ev_pop;
    int     wp_mode;
    bit     rand_wait;
    logic [63:0]  last_addr, last_be;
    logic [31:0]  last_d32;
    logic [511:0] last_dhi;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] flit(input int r, input int k);
        return {16{(32'(r) << 24) | 32'(k)}};
    endfunction

    function automatic int rr_pick();
        for (int i = 1; i <= NB; i++) begin
            if (req_valid[(last_g + i) % NB]) return (last_g + i) % NB;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int r = 0; r < NB; r++) if (hq[r].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_req();
        for (int r = 0; r < NB; r++) begin
            req_valid[r]               = (hq[r].size() != 0);
            req_addr[r*64 +: 64]       = req_valid[r] ? hq[r][0].addr  : 64'd0;
            req_len[r*4 +: 4]          = req_valid[r] ? hq[r][0].len   : 4'd0;
            req_ptr_addr[r*64 +: 64]   = req_valid[r] ? hq[r][0].paddr : 64'd0;
            req_ptr_val[r*32 +: 32]    = req_valid[r] ? hq[r][0].pval  : 32'd0;
            req_data[r*512 +: 512]     = flit(r, popped[r]);
        end
    endtask

    task automatic drive_bus();
        if (plan.size() != 0) pcie_bas_waitrequest = plan.pop_front();
        else pcie_bas_waitrequest = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
        write_pointer = (wp_mode == 2) ? 1'($urandom_range(0, 1)) : (wp_mode == 1);
    endtask

    task automatic load(input int r, input logic [63:0] a, input int len,
                        input logic [63:0] pa, input logic [31:0] pv);
        hdr_t h;
        h.addr = a; h.len = 4'(len); h.paddr = pa; h.pval = pv;
        hq[r].push_back(h);
        drive_req();
    endtask

    // Compare one cycle of DUT outputs with the model, then advance the model
    task automatic monitor();
        logic [NB-1:0] eg, ep;
        int w;
        bit idle, acc;
        beat_t b, nb;
        hdr_t h;
        eg = '0; ep = '0; w = -1;
        idle = (expq.size() == 0);
        if (!rst && idle && |req_valid) begin
            w = rr_pick();
            eg[w] = 1'b1;
        end
        chk("grant", req_grant, eg);
        chk("busy", busy, !idle);
        chk("write", pcie_bas_write, !idle);
        if (rst) chk("rst_bus", {pcie_bas_address, pcie_bas_byteenable, pcie_bas_burstcount, pcie_bas_writedata}, '0);
        acc = 1'b0;
        if (!idle) begin
            b = expq[0];
            chk("address", pcie_bas_address, b.addr);
            chk("burstcount", pcie_bas_burstcount, b.bc);
            chk("byteenable", pcie_bas_byteenable, b.be);
            chk("writedata", pcie_bas_writedata, b.data);
            acc = !pcie_bas_waitrequest;
            if (acc && b.is_data) ep[b.req] = 1'b1;
        end
        chk("pop", req_pop, ep);
        chk("burst_cnt", burst_cnt, 32'(m_burst));
        chk("bad_len_cnt", bad_len_cnt, 32'(m_bad));
        if (|req_grant) begin
            n_grant++;
            for (int r = 0; r < NB; r++) if (req_grant[r]) glog.push_back(r);
        end
        if (pcie_bas_write) n_wr++;
        if (|req_pop) n_pop++;
        ev_grant = -1; ev_pop = -1;
        if (acc) begin
            void'(expq.pop_front());
            last_addr = pcie_bas_address;
            last_be   = pcie_bas_byteenable;
            last_d32  = pcie_bas_writedata[31:0];
            last_dhi  = pcie_bas_writedata >> 32;
            if (b.is_data) begin
                ev_pop = b.req;
                n_beats++;
            end
            if (b.last) begin
                m_burst++;
                if (write_pointer) begin
                    nb = b;
                    nb.addr = b.paddr; nb.bc = 4'd1; nb.be = 64'hF;
                    nb.data = {480'd0, b.pval}; nb.is_data = 1'b0; nb.last = 1'b0;
                    expq.push_back(nb);
                end
            end
        end
        if (w >= 0) begin
            h = hq[w][0];
            last_g = w;
            ev_grant = w;
            if (h.len == 0 || int'(h.len) > MB) begin
                m_bad++;
            end else begin
                for (int j = 0; j < int'(h.len); j++) begin
                    nb.addr = h.addr; nb.bc = h.len; nb.be = '1;
                    nb.data = flit(w, popped[w] + j); nb.req = w; nb.is_data = 1'b1;
                    nb.last = (j == int'(h.len) - 1); nb.paddr = h.paddr; nb.pval = h.pval;
                    expq.push_back(nb);
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (ev_grant >= 0) void'(hq[ev_grant].pop_front());
        if (ev_pop >= 0) popped[ev_pop]++;
        drive_req();
        drive_bus();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((pending() || expq.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        cycle();
        chk(tag, n < budget, 1'b1);
    endtask

    task automatic clr_stats();
        n_grant = 0; n_wr = 0; n_pop = 0; n_beats = 0;
        glog.delete();
    endtask

    task automatic model_reset();
        expq.delete();
        for (int r = 0; r < NB; r++) begin
            hq[r].delete();
            popped[r] = 0;
        end
        last_g = NB - 1; m_burst = 0; m_bad = 0;
        drive_req();
    endtask

    initial begin
        int n;
        rst = 1'b1; wp_mode = 0; rand_wait = 1'b0;
        req_valid = '0; req_addr = '0; req_len = '0; req_data = '0;
        req_ptr_addr = '0; req_ptr_val = '0; write_pointer = 1'b0; pcie_bas_waitrequest = 1'b0;
        model_reset();
        clr_stats();

        // Reset state, with headers already pending (grant must stay low)
        load(0, 64'h100, 1, 64'h0, 32'h0);
        load(0, 64'h140, 1, 64'h0, 32'h0);
        load(1, 64'h200, 1, 64'h0, 32'h0);
        load(2, 64'h300, 1, 64'h0, 32'h0);
        load(3, 64'h400, 1, 64'h0, 32'h0);
        #1;
        chk("rst_grant", req_grant, '0);
        chk("rst_write", pcie_bas_write, 1'b0);
        repeat (3) cycle();
        rst = 1'b0;

        // All four valid, len 1: round-robin order from requester 0
        drain("rr_drain", 200);
        chk("rr_count", glog.size(), 5);
        for (int i = 0; i < 5; i++) chk("rr_order", glog[i], i % 4);
        chk("rr_burst_cnt", burst_cnt, 32'd5);

        // Stalled burst: requester 2, len 4, three wait cycles after beat 1
        clr_stats();
        plan = '{1'b0, 1'b1, 1'b1, 1'b1};
        load(2, 64'h1000, 4, 64'h0, 32'h0);
        drain("stall_drain", 100);
        chk("stall_pops", n_pop, 4);
        chk("stall_wr_cycles", n_wr, 7);

        // Pointer write after a two-beat burst
        clr_stats();
        wp_mode = 1;
        load(1, 64'h2000, 2, 64'h40, 32'd7);
        drain("ptr_drain", 100);
        chk("ptr_wr_cycles", n_wr, 3);
        chk("ptr_addr", last_addr, 64'h40);
        chk("ptr_be", last_be, 64'hF);
        chk("ptr_val", last_d32, 32'd7);
        chk("ptr_upper", last_dhi, '0);
        wp_mode = 0;

        // Bad lengths are granted and dropped
        clr_stats();
        load(0, 64'h3000, 0, 64'h0, 32'h0);
        load(0, 64'h3040, 9, 64'h0, 32'h0);
        drain("bad_drain", 100);
        chk("bad_writes", n_wr, 0);
        chk("bad_grants", n_grant, 2);
        chk("bad_len_cnt_val", bad_len_cnt, 32'd2);

        // Reset in the middle of an 8-flit burst
        clr_stats();
        load(1, 64'h4000, 8, 64'h0, 32'h0);
        n = 0;
        while (n_beats < 2 && n < 100) begin
            cycle();
            n++;
        end
        chk("rst_wait", n_beats, 2);
        chk("pre_rst_write", pcie_bas_write, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_write", pcie_bas_write, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_burst_cnt", burst_cnt, 32'd0);
        chk("mid_rst_bad_cnt", bad_len_cnt, 32'd0);
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
        clr_stats();
        load(3, 64'h5000, 1, 64'h0, 32'h0);
        load(2, 64'h5100, 1, 64'h0, 32'h0);
        load(0, 64'h5200, 1, 64'h0, 32'h0);
        drain("post_rst_drain", 100);
        chk("post_rst_count", glog.size(), 3);
        chk("post_rst_first", glog[0], 0);

        // Late arrival on requester 0 wins the next idle slot over requester 3
        clr_stats();
        load(3, 64'h6000, 8, 64'h0, 32'h0);
        load(3, 64'h6200, 8, 64'h0, 32'h0);
        n = 0;
        while (n_beats < 3 && n < 100) begin
            cycle();
            n++;
        end
        chk("late_wait", n_beats, 3);
        load(0, 64'h7000, 2, 64'h0, 32'h0);
        drain("late_drain", 200);
        chk("late_count", glog.size(), 3);
        for (int i = 0; i < 3; i++) chk("late_order", glog[i], (i == 1) ? 0 : 3);

        // Random traffic: random lengths (incl. bad), stalls and pointer mode
        clr_stats();
        wp_mode = 2;
        rand_wait = 1'b1;
        for (int i = 0; i < 40; i++) begin
            load($urandom_range(0, NB - 1), {$urandom, $urandom} & ~64'h3F,
                 $urandom_range(0, 10), {$urandom, $urandom} & ~64'h3, $urandom);
        end
        drain("rand_drain", 8000);
        chk("rand_grants", n_grant, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_dma_wr_arbiter.md
PCIE_DMA_WR_ARBITER -- requirements
Module: pcie_dma_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NB_REQ, default 4: the number of requesters (DMA queues), range 2..16.
REQ-002 The block SHALL have parameter MAX_BURST, default 8: the maximum flits per Avalon burst.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, NB_REQ bits: per-requester burst header valid.
REQ-006 The block SHALL have port req_addr, input, NB_REQ*64 bits: per-requester host byte address of the burst, 64B-aligned.
REQ-007 The block SHALL have port req_len, input, NB_REQ*4 bits: per-requester burst length in flits.
REQ-008 The block SHALL have port req_data, input, NB_REQ*512 bits: per-requester show-ahead head flit.
REQ-009 The block SHALL have port req_ptr_addr, input, NB_REQ*64 bits: per-requester host address of the tail-pointer word.
REQ-010 The block SHALL have port req_ptr_val, input, NB_REQ*32 bits: per-requester tail-pointer value to publish.
REQ-011 The block SHALL have port write_pointer, input, 1 bit: when 1, a pointer write follows each data burst.
REQ-012 The block SHALL have port req_grant, output, NB_REQ bits: one-hot header-accept pulse.
REQ-013 The block SHALL have port req_pop, output, NB_REQ bits: one-hot pulse meaning the head flit was consumed.
REQ-014 The block SHALL have port pcie_bas_waitrequest, input, 1 bit: Avalon stall.
REQ-015 The block SHALL have the following Avalon write-master outputs:
- pcie_bas_address, 64 bits
- pcie_bas_byteenable, 64 bits
- pcie_bas_write, 1 bit
- pcie_bas_writedata, 512 bits
- pcie_bas_burstcount, 4 bits
REQ-016 The block SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-017 The block SHALL have ports burst_cnt and bad_len_cnt, output, 32 bits each: completed data bursts and dropped headers.

Function
REQ-018 The FSM SHALL have states IDLE, DATA and PTR.
REQ-019 In IDLE, if any req_valid bit is set, the block SHALL:
- grant the first valid requester scanning upward from (last_grant+1) mod NB_REQ;
- pulse req_grant for that requester for 1 cycle;
- latch the requester's addr, len, ptr_addr and ptr_val;
- go to DATA.
REQ-020 The first data beat SHALL be presented on the cycle after the grant; grant-to-first-beat latency is 1 cycle.
REQ-021 In DATA, the block SHALL drive the following:
- pcie_bas_write=1
- pcie_bas_address = latched addr
- pcie_bas_burstcount = latched len
- pcie_bas_byteenable all ones
- pcie_bas_writedata = req_data of the granted requester
REQ-022 In DATA, address and burstcount SHALL stay constant for the whole burst.
REQ-023 A beat SHALL be accepted when pcie_bas_write=1 and pcie_bas_waitrequest=0; req_pop SHALL pulse only on an accepted beat.
REQ-024 While waitrequest=1, all pcie_bas_* outputs SHALL hold and no req_pop SHALL occur.
REQ-025 When the last beat (beat count = len) is accepted, burst_cnt SHALL increment and the FSM SHALL go to PTR if write_pointer=1, otherwise to IDLE.
REQ-026 In PTR, the block SHALL issue one write: write=1, address=ptr_addr, burstcount=1, byteenable=64'hF, writedata[31:0]=ptr_val, other bits 0. On acceptance the FSM SHALL go to IDLE.
REQ-027 The block SHALL NOT issue back-to-back grants: there is at least one IDLE cycle between bursts.
REQ-028 last_grant SHALL update only on a grant.
REQ-029 Round-robin SHALL make every continuously valid requester wait at most NB_REQ-1 bursts.
REQ-030 A header with req_len=0 or req_len>MAX_BURST SHALL be granted, then dropped with no bus activity: bad_len_cnt increments and the FSM stays in IDLE.
REQ-031 Outside DATA and PTR, pcie_bas_write SHALL be 0 and req_pop SHALL be 0.
REQ-032 write_pointer SHALL be sampled at the last accepted data beat; changes mid-burst SHALL have no effect on the current burst.
REQ-033 burst_cnt and bad_len_cnt SHALL wrap modulo 2^32.

Reset
REQ-034 When rst asserts, at any time, the block SHALL immediately:
- put the FSM in IDLE;
- set last_grant = NB_REQ-1, so requester 0 is granted first;
- clear all outputs (req_grant, req_pop, pcie_bas_*, busy, burst_cnt, bad_len_cnt) to 0.
REQ-035 A burst interrupted by rst SHALL be abandoned with no completion of the remaining beats; requesters SHALL be reset by the same rst.

Verification
REQ-036 A bench SHALL cover: all 4 requesters valid with len=1 and write_pointer=0 -> grants in order 0,1,2,3,0. burst_cnt=5 after 5 bursts.
REQ-037 A bench SHALL cover: requester 2 alone with len=4 at addr 0x1000, waitrequest=1 on beats 2-3 for 3 cycles -> 4 pops, address 0x1000 and burstcount 4 steady throughout, total 4+3 write cycles.
REQ-038 A bench SHALL cover: write_pointer=1, requester 1 with len=2 and ptr_addr 0x40, ptr_val 7 -> 2 data beats, then 1 write to 0x40 with byteenable 0xF and writedata[31:0]=7.
REQ-039 A bench SHALL cover: requester 0 with req_len=0, then requester 0 with req_len=9 -> no pcie_bas_write, bad_len_cnt=2, and 2 grant pulses.
REQ-040 A bench SHALL cover: rst asserted on beat 3 of an 8-flit burst -> write=0 in the same cycle. After release, requester 0 is granted first.
REQ-041 A bench SHALL cover: requester 3 valid continuously with len=8 while requester 0 asserts valid mid-burst -> requester 0 is granted in the next IDLE.
